vga_src_switch: RTL

VGA_SRC_SWITCH -- requirements
Module: vga_src_switch

---
 rtl/vga_src_switch_pkg.sv | 12 +
 rtl/vga_src_switch_btn_debounce.sv | 48 ++++
 rtl/vga_src_switch.sv | 110 +++++++++++
 3 files changed

// File: rtl/vga_src_switch_pkg.sv
// rtl/vga_src_switch_pkg.sv - shared types and timing defaults for the VGA source switch
package vga_src_switch_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } sw_state_t;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

endpackage

// File: rtl/vga_src_switch_btn_debounce.sv
// rtl/vga_src_switch_btn_debounce.sv - push-button synchroniser, debouncer and press detector
module btn_debounce #(
    parameter int DEB_CYC = 1000000
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic button_i,
    output logic press_o
);

    localparam int CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic             sync_q;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync_q  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= button_i;
            sync2   <= sync1;
            sync_q  <= sync2;
            level_q <= level;
            // Counter saturates at the last value so a long-stable level keeps being accepted
            if (sync2 != sync_q) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
            if (sync2 == sync_q && cnt == CNT_LAST) begin
                level <= sync2;
            end
        end
    end

    assign press_o = level & ~level_q;

endmodule

// File: rtl/vga_src_switch.sv
// rtl/vga_src_switch.sv - frame-synchronous N-way VGA source selector with blanking
module vga_src_switch
    import vga_src_switch_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int CH_W    = 1,
    parameter int DEB_CYC = 1000000,
    parameter int SEL_RST = 0,
    parameter int H_ACT   = H_ACT_DEF,
    parameter int V_ACT   = V_ACT_DEF,
    localparam int SEL_W  = (N_SRC > 2) ? $clog2(N_SRC) : 1,
    localparam int PIX_W  = 3 * CH_W
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   buton_i,
    input  logic [N_SRC*PIX_W-1:0] src_rgb_i,
    input  logic [8:0]             row_i,
    input  logic [9:0]             column_i,
    input  logic                   hSync_i,
    input  logic                   vSync_i,
    output logic [PIX_W-1:0]       rgb_o,
    output logic                   hSync_o,
    output logic                   vSync_o,
    output logic [SEL_W-1:0]       sel_o,
    output logic                   pending_o
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_SRC - 1);

    sw_state_t        state;
    logic [SEL_W-1:0] sel;
    logic             press;
    logic             vs_q;
    logic             vs_q2;
    logic             frame_start;
    logic [PIX_W-1:0] pix_sel;
    logic [PIX_W-1:0] pix1;
    logic             act1;
    logic             hs1;

    btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .button_i  (buton_i),
        .press_o   (press)
    );

    assign frame_start = vs_q2 & ~vs_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
            sel   <= SEL_W'(SEL_RST);
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (press) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (frame_start) begin
                        sel   <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pix_sel = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                pix_sel = src_rgb_i[k*PIX_W +: PIX_W];
            end
        end
    end

    // vs_q doubles as stage 1 of the vSync delay line
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pix1    <= '0;
            act1    <= 1'b0;
            hs1     <= 1'b1;
            vs_q    <= 1'b1;
            vs_q2   <= 1'b1;
            rgb_o   <= '0;
            hSync_o <= 1'b1;
            vSync_o <= 1'b1;
        end else begin
            pix1    <= pix_sel;
            act1    <= (column_i < 10'(H_ACT)) && (row_i < 9'(V_ACT));
            hs1     <= hSync_i;
            vs_q    <= vSync_i;
            vs_q2   <= vs_q;
            rgb_o   <= act1 ? pix1 : '0;
            hSync_o <= hs1;
            vSync_o <= vs_q;
        end
    end

    assign sel_o     = sel;
    assign pending_o = (state == ST_PENDING);

endmodule
